// File: rtl/pwm_pkg.sv
// Shared constants and output-mode decoding for the PWM output stage.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W   = 8;
    localparam logic [7:0]  PWM_CNT_MAX = 8'd254;
    localparam logic [7:0]  DUTY_FULL   = 8'hFF;
    localparam int unsigned NUM_OUT     = 16;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STATIC = 2'b01,
        MODE_PWM    = 2'b10
    } out_mode_e;

    // PWM select only matters while the output is enabled.
    function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return MODE_OFF;
        end else if (!en_pwm) begin
            return MODE_STATIC;
        end else begin
            return MODE_PWM;
        end
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running tick generator: one-cycle tick every PRESCALE clk cycles.
module pwm_prescaler #(
    parameter int unsigned PRESCALE   = 13,
    parameter int unsigned PRESCALE_W = $clog2(PRESCALE) + 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == PRESCALE_W'(PRESCALE - 1));
        cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM stage fed by the SPI register file.
// Optional PWM_DUTY_SHADOW_EN: duty is latched on period wrap for glitch-free periods.
module pwm_peripheral #(
    parameter int unsigned PRESCALE   = 13,
    parameter int unsigned PRESCALE_W = $clog2(PRESCALE) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    import pwm_pkg::*;

    logic                 tick;
    logic                 wrap;
    logic                 pwm_level;
    logic [NUM_OUT-1:0]   en_out;
    logic [NUM_OUT-1:0]   en_pwm;
    logic [PWM_CNT_W-1:0] duty_active;

    logic [PWM_CNT_W-1:0] pwm_cnt_q;
    logic [PWM_CNT_W-1:0] pwm_cnt_d;
    logic                 period_start_q;
    logic                 period_start_d;
    logic [NUM_OUT-1:0]   out_q;
    logic [NUM_OUT-1:0]   out_d;

    pwm_prescaler #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign wrap   = tick && (pwm_cnt_q == PWM_CNT_MAX);

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_CNT_W-1:0] duty_q;
    logic [PWM_CNT_W-1:0] duty_d;

    always_comb begin
        duty_d = wrap ? pwm_duty_cycle : duty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_active = duty_q;
`else
    assign duty_active = pwm_duty_cycle;
`endif

    // Counter runs 0..254 so that a duty of 0xFF can be forced fully on.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = wrap ? '0 : pwm_cnt_q + PWM_CNT_W'(1);
        end
        period_start_d = wrap;
        pwm_level      = (duty_active == DUTY_FULL) || (pwm_cnt_q < duty_active);
    end

    always_comb begin
        out_d = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            case (out_mode(en_out[i], en_pwm[i]))
                MODE_OFF:    out_d[i] = 1'b0;
                MODE_STATIC: out_d[i] = 1'b1;
                MODE_PWM:    out_d[i] = pwm_level;
                default:     out_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
            out_q          <= '0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (PRESCALE=2, period 510 clk).
module tb_pwm_peripheral;

    localparam int unsigned P      = 2;
    localparam int unsigned PERIOD = 255 * P;

    typedef struct packed {
        logic [15:0] o;
        logic        ps;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_out_r;
    logic [15:0] en_pwm_r;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        period_start;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned mk      = 0;
    logic [7:0]  shadow  = 8'h00;
    exp_t        sb_q[$];

    pwm_peripheral #(
        .PRESCALE   (P),
        .PRESCALE_W (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out_r[7:0]),
        .en_reg_out_15_8 (en_out_r[15:8]),
        .en_reg_pwm_7_0  (en_pwm_r[7:0]),
        .en_reg_pwm_15_8 (en_pwm_r[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model from elapsed cycles since reset; expectation pushed before the edge, checked after.
    task automatic cycle();
        exp_t        e;
        int unsigned kn;
        logic [7:0]  cnt_prev;
        logic [7:0]  duty_act;
        logic        lvl;
        if (rst) begin
            e      = '0;
            mk     = 0;
            shadow = 8'h00;
        end else begin
            kn       = mk + 1;
            cnt_prev = 8'((mk % PERIOD) / P);
`ifdef PWM_DUTY_SHADOW_EN
            duty_act = shadow;
`else
            duty_act = duty;
`endif
            lvl  = (duty_act == 8'hFF) || (cnt_prev < duty_act);
            e.o  = en_out_r & (~en_pwm_r | {16{lvl}});
            e.ps = ((kn % PERIOD) == 0);
            if ((kn % PERIOD) == 0) shadow = duty;
            mk = kn;
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("out", {16'h0, out}, {16'h0, e.o});
        check("period_start", {31'h0, period_start}, {31'h0, e.ps});
    endtask

    task automatic cycles_to_ps(output int unsigned n);
        n = 0;
        for (int unsigned i = 0; i < 2 * PERIOD; i++) begin
            cycle();
            n++;
            if (period_start === 1'b1) break;
        end
    endtask

    task automatic wait_ps();
        int unsigned n;
        cycles_to_ps(n);
        if (period_start !== 1'b1) check("ps_timeout", 32'd0, 32'd1);
    endtask

    // Counts high samples of two bits over nper periods; optional duty change at sample chg_at.
    task automatic measure(input int unsigned nper, input int unsigned b0, input int unsigned b1,
                           input int chg_at, input logic [7:0] new_duty,
                           output int unsigned c0, output int unsigned c1);
        c0 = 0;
        c1 = 0;
        wait_ps();
        for (int i = 0; i < int'(nper * PERIOD); i++) begin
            if (i == chg_at) duty = new_duty;
            cycle();
            c0 += 32'(out[b0]);
            c1 += 32'(out[b1]);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned c0;
        int unsigned c1;

        rst      = 1'b1;
        en_out_r = 16'hFFFF;
        en_pwm_r = 16'hFFFF;
        duty     = 8'hFF;
        cycle();
        cycle();
        check("rst_out", {16'h0, out}, 32'h0);
        rst = 1'b0;
        cycles_to_ps(n);
        check("first_ps_delay", n, PERIOD);

        en_out_r = 16'hA55A;
        en_pwm_r = 16'h0000;
        cycle();
        check("static_on", {16'h0, out}, 32'hA55A);
        repeat (5) cycle();
        en_out_r = 16'h0000;
        cycle();
        check("static_off", {16'h0, out}, 32'h0);

        en_out_r = 16'h0001;
        en_pwm_r = 16'h0001;
        duty     = 8'h80;
        measure(1, 0, 0, -1, 8'h00, c0, c1);
        check("duty80_high", c0, 256);

        duty = 8'h00;
        measure(1, 0, 0, -1, 8'h00, c0, c1);
        check("duty00_high", c0, 0);
        duty = 8'hFF;
        measure(3, 0, 0, -1, 8'h00, c0, c1);
        check("dutyFF_high", c0, 3 * PERIOD);
        duty = 8'h01;
        measure(1, 0, 0, -1, 8'h00, c0, c1);
        check("duty01_high", c0, 2);

        en_out_r = 16'hFFFF;
        en_pwm_r = 16'h00F0;
        duty     = 8'h40;
        measure(1, 4, 7, -1, 8'h00, c0, c1);
        check("mixed_bit4", c0, 128);
        check("mixed_bit7", c1, 128);

        en_out_r = 16'h0001;
        en_pwm_r = 16'h0001;
        measure(1, 0, 0, -1, 8'h00, c0, c1);
        check("pre_change", c0, 128);
        measure(1, 0, 0, 160, 8'hC0, c0, c1);
`ifdef PWM_DUTY_SHADOW_EN
        check("mid_change_cur", c0, 128);
`else
        check("mid_change_cur", c0, 352);
`endif
        measure(1, 0, 0, -1, 8'h00, c0, c1);
        check("mid_change_next", c0, 384);
        measure(1, 0, 0, 509, 8'h40, c0, c1);
        check("wrap_change_cur", c0, 384);
        measure(1, 0, 0, -1, 8'h00, c0, c1);
        check("wrap_change_next", c0, 128);

        repeat (100) cycle();
        rst = 1'b1;
        cycle();
        check("midrst_out", {16'h0, out}, 32'h0);
        rst = 1'b0;
        cycles_to_ps(n);
        check("midrst_ps_delay", n, PERIOD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
